// File: rtl/l1_cache_pkg.sv
// l1_cache_pkg: shared types, default sizes and address-split helpers
// for the L1 instruction cache.
package l1_cache_pkg;

    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_SETS       = 16;
    localparam int DEF_LINE_WORDS = 4;

    typedef enum logic [2:0] {
        IDLE,
        MISS_REQ,
        REFILL,
        RESPOND,
        FLUSH
    } state_t;

    function automatic int off_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int addr_w, input int sets,
                                    input int line_words);
        return addr_w - $clog2(sets) - $clog2(line_words);
    endfunction

endpackage

// File: rtl/l1_icache_tag.sv
// l1_icache_tag: tag/valid store of the direct-mapped icache.
// Combinational lookup, single write port, one-cycle flush of all valid bits.
module l1_icache_tag
    import l1_cache_pkg::*;
#(
    parameter int SETS  = DEF_SETS,
    parameter int IDX_W = 4,
    parameter int TAG_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             hit,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             clr
);

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags [SETS];

    // Valid bits: cleared by reset or flush, set when a line is filled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (clr) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag array carries no reset; the valid bit qualifies it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_tag;
        end
    end

    assign hit = valid[rd_idx] && (tags[rd_idx] == rd_tag);

endmodule

// File: rtl/l1_icache.sv
// l1_icache: direct-mapped instruction cache with line refill and flush.
// Optional macro L1_ICACHE_STATS_EN adds saturating hit/miss counters.
module l1_icache
    import l1_cache_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SETS       = DEF_SETS,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              flush,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data
`ifdef L1_ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int OFF_W = off_bits(LINE_WORDS);
    localparam int IDX_W = idx_bits(SETS);
    localparam int TAG_W = tag_bits(ADDR_W, SETS, LINE_WORDS);
    localparam int DEPTH = SETS * LINE_WORDS;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    state_t state;
    state_t state_nx;

    logic [ADDR_W-1:0] addr_q;
    logic [OFF_W-1:0]  beat_q;
    logic              flush_pend;
    logic              hit;
    logic              accept;
    logic              beat_we;
    logic              last_beat;
    logic              tag_clr;

    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [OFF_W-1:0] q_off;
    logic [IDX_W-1:0] q_idx;
    logic [TAG_W-1:0] q_tag;

    logic [DATA_W-1:0] data_mem [DEPTH];

    assign req_off = req_addr[OFF_W-1:0];
    assign req_idx = req_addr[OFF_W +: IDX_W];
    assign req_tag = req_addr[ADDR_W-1 -: TAG_W];
    assign q_off   = addr_q[OFF_W-1:0];
    assign q_idx   = addr_q[OFF_W +: IDX_W];
    assign q_tag   = addr_q[ADDR_W-1 -: TAG_W];

    assign accept    = clk_en && req_valid && req_ready;
    assign beat_we   = clk_en && (state == REFILL) && mem_rsp_valid;
    assign last_beat = beat_we && (beat_q == LAST_BEAT);
    assign tag_clr   = clk_en && (state == FLUSH);

    assign mem_req_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    l1_icache_tag #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_tag (
        .clk    (clk),
        .rst    (rst),
        .rd_idx (req_idx),
        .rd_tag (req_tag),
        .hit    (hit),
        .wr_en  (last_beat),
        .wr_idx (q_idx),
        .wr_tag (q_tag),
        .clr    (tag_clr)
    );

    // State register; clk_en low freezes the controller.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (clk_en) begin
            state <= state_nx;
        end
    end

    // Next state: flush beats any request; a pending flush runs once idle.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (flush || flush_pend) begin
                    state_nx = FLUSH;
                end else if (req_valid && !hit) begin
                    state_nx = MISS_REQ;
                end
            end
            MISS_REQ: begin
                if (mem_req_ready) begin
                    state_nx = REFILL;
                end
            end
            REFILL: begin
                if (mem_rsp_valid && (beat_q == LAST_BEAT)) begin
                    state_nx = RESPOND;
                end
            end
            RESPOND: state_nx = IDLE;
            FLUSH:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        unique case (state)
            IDLE:     req_ready = !flush && !flush_pend;
            MISS_REQ: mem_req_valid = 1'b1;
            default:  ;
        endcase
    end

    // Request capture, beat counter, deferred flush and response register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            beat_q     <= '0;
            flush_pend <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
        end else if (clk_en) begin
            rsp_valid <= 1'b0;
            if (accept) begin
                addr_q <= req_addr;
            end
            if (accept && hit) begin
                rsp_valid <= 1'b1;
                rsp_data  <= data_mem[{req_idx, req_off}];
            end
            if (state == RESPOND) begin
                rsp_valid <= 1'b1;
                rsp_data  <= data_mem[{q_idx, q_off}];
            end
            if (beat_we) begin
                beat_q <= beat_q + 1'b1;
            end
            if (state == FLUSH) begin
                flush_pend <= 1'b0;
            end else if (flush && state != IDLE) begin
                flush_pend <= 1'b1;
            end
        end
    end

    // Line data store; each refill beat fills the next word of the line.
    always_ff @(posedge clk) begin
        if (beat_we) begin
            data_mem[{q_idx, beat_q}] <= mem_rsp_data;
        end
    end

`ifdef L1_ICACHE_STATS_EN
    // Saturating hit/miss counters over accepted requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept) begin
            if (hit && hit_count != '1) begin
                hit_count <= hit_count + 1'b1;
            end
            if (!hit && miss_count != '1) begin
                miss_count <= miss_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_l1_icache.sv
// tb_l1_icache: randomized and directed bench for l1_icache with a
// line-level cache model, a memory responder and a per-cycle checker.
module tb_l1_icache;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          clk_en;
    logic          flush;
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          mem_req_valid;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_ready;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;

    always #5 clk = ~clk;

    l1_icache #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .SETS       (16),
        .LINE_WORDS (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clk_en        (clk_en),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
    );

    int total = 0;
    int bad   = 0;

    // cache model: which line each set holds
    bit          mv [16];
    int unsigned mt [16];
    logic [DW-1:0] exp_q  [$];
    logic [AW-1:0] miss_q [$];

    int            refills = 0;
    int            cyc = 0;
    int            rsp_cyc [$];
    logic [DW-1:0] last_rsp = '0;

    // memory responder state
    bit            busy = 0;
    bit            start_next = 0;
    int            beat = 0;
    int            hold = 0;
    logic [AW-1:0] base = '0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a, ~a};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // memory side: random ready, random beat gaps, stray beats when idle
    initial begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = $urandom;
            if (rst) begin
                busy = 0;
                start_next = 0;
                beat = 0;
                hold = 0;
                continue;
            end
            if (start_next) begin
                busy = 1;
                start_next = 0;
                beat = 0;
            end
            if (busy) begin
                if (clk_en && $urandom_range(0, 3) != 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = mem_word(base + AW'(beat));
                    beat++;
                    if (beat == 4) begin
                        busy = 0;
                        beat = 0;
                    end
                end
            end else begin
                if ($urandom_range(0, 4) == 0) mem_rsp_valid = 1'b1;
                if (mem_req_valid) begin
                    if (hold > 0) begin
                        if (clk_en) hold--;
                    end else if ($urandom_range(0, 2) != 0) begin
                        mem_req_ready = 1'b1;
                        if (clk_en) begin
                            start_next = 1;
                            base = mem_req_addr;
                        end
                    end
                end
            end
        end
    end

    // per-cycle checker: responses, refill addresses, request stability
    initial begin
        bit            en_last = 0;
        bit            pv = 0;
        bit            phs = 0;
        bit            hs;
        logic [AW-1:0] pa = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                en_last = 0;
                pv = 0;
                phs = 0;
                continue;
            end
            if (rsp_valid && en_last) begin
                chk("rsp_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0)
                    chk("rsp_data", 64'(rsp_data), 64'(exp_q.pop_front()));
                last_rsp = rsp_data;
                rsp_cyc.push_back(cyc);
            end
            if (pv && !phs) begin
                chk("mreq_held", 64'(mem_req_valid), 64'(1));
                chk("mreq_addr_stable", 64'(mem_req_addr), 64'(pa));
            end
            hs = mem_req_valid && mem_req_ready && clk_en;
            if (hs) begin
                chk("refill_expected", 64'(miss_q.size() != 0), 64'(1));
                if (miss_q.size() != 0)
                    chk("refill_addr", 64'(mem_req_addr), 64'(miss_q.pop_front()));
                refills++;
            end
            pv = mem_req_valid;
            pa = mem_req_addr;
            phs = hs;
            en_last = clk_en;
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mv[i] = 0;
        exp_q.delete();
        miss_q.delete();
    endtask

    task automatic rd(input logic [AW-1:0] a);
        int n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        forever begin
            #3;
            if (req_ready && clk_en) break;
            @(negedge clk);
            n++;
            if (n > 300) begin
                chk("accept_timeout", 64'(n), 64'(0));
                req_valid = 1'b0;
                return;
            end
        end
        exp_q.push_back(mem_word(a));
        if (!(mv[a[5:2]] && mt[a[5:2]] == 32'(a[15:6]))) begin
            miss_q.push_back({a[15:2], 2'b00});
            mv[a[5:2]] = 1;
            mt[a[5:2]] = 32'(a[15:6]);
        end
        @(negedge clk);
    endtask

    task automatic fl();
        flush = 1'b1;
        for (int i = 0; i < 16; i++) mv[i] = 0;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic wait_quiet();
        int n = 0;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        while (!(exp_q.size() == 0 && miss_q.size() == 0 && !busy &&
                 !start_next && req_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("quiet_timeout", 64'(n), 64'(0));
    endtask

    task automatic wait_beat(input int b);
        int n = 0;
        while (!(busy && beat >= b) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("beat_wait", 64'(n < 200), 64'(1));
    endtask

    initial begin
        int r0;
        int sz;
        logic [AW-1:0] a;
        rst = 1'b1;
        clk_en = 1'b1;
        flush = 1'b0;
        req_valid = 1'b0;
        req_addr = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_data", 64'(rsp_data), 64'(0));
        chk("rst_mreq_valid", 64'(mem_req_valid), 64'(0));
        chk("rst_mreq_addr", 64'(mem_req_addr), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        #3;
        chk("ready_after_rst", 64'(req_ready), 64'(1));
        @(negedge clk);

        // cold miss on 0x0042
        r0 = refills;
        rd(16'h0042);
        req_valid = 1'b0;
        chk("cold_mreq_valid", 64'(mem_req_valid), 64'(1));
        chk("cold_mreq_addr", 64'(mem_req_addr), 64'(16'h0040));
        wait_quiet();
        chk("cold_rsp", 64'(last_rsp), 64'(32'h0042_FFBD));
        chk("cold_refills", 64'(refills - r0), 64'(1));

        // back-to-back hits
        r0 = refills;
        rd(16'h0040);
        rd(16'h0041);
        rd(16'h0043);
        wait_quiet();
        sz = rsp_cyc.size();
        chk("b2b_refills", 64'(refills - r0), 64'(0));
        chk("b2b_consec", 64'(rsp_cyc[sz-1] - rsp_cyc[sz-3]), 64'(2));
        chk("b2b_last", 64'(last_rsp), 64'(32'h0043_FFBC));

        // conflict on the same index
        r0 = refills;
        rd(16'h0140);
        wait_quiet();
        chk("conflict_refill", 64'(refills - r0), 64'(1));
        rd(16'h0042);
        wait_quiet();
        chk("conflict_reread", 64'(refills - r0), 64'(2));
        chk("conflict_rsp", 64'(last_rsp), 64'(32'h0042_FFBD));

        // flush during refill
        r0 = refills;
        rd(16'h0080);
        req_valid = 1'b0;
        wait_beat(1);
        fl();
        wait_quiet();
        chk("flushref_rsp", 64'(last_rsp), 64'(32'h0080_FF7F));
        rd(16'h0080);
        wait_quiet();
        chk("flushref_remiss", 64'(refills - r0), 64'(2));

        // flush and request in the same cycle
        r0 = refills;
        req_valid = 1'b1;
        req_addr = 16'h0042;
        flush = 1'b1;
        for (int i = 0; i < 16; i++) mv[i] = 0;
        #3;
        chk("flush_wins", 64'(req_ready), 64'(0));
        @(negedge clk);
        flush = 1'b0;
        rd(16'h0042);
        wait_quiet();
        chk("flush_wins_miss", 64'(refills - r0), 64'(1));

        // stalled memory request, then reset mid-refill
        r0 = refills;
        hold = 5;
        rd(16'h00C4);
        req_valid = 1'b0;
        wait_beat(2);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk("abort_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("abort_mreq_valid", 64'(mem_req_valid), 64'(0));
        chk("abort_mreq_addr", 64'(mem_req_addr), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        #3;
        chk("abort_ready", 64'(req_ready), 64'(1));
        @(negedge clk);
        rd(16'h00C4);
        wait_quiet();
        chk("abort_remiss", 64'(refills - r0), 64'(2));
        chk("abort_rsp", 64'(last_rsp), 64'(32'h00C4_FF3B));

        // clock enable dropped mid-refill
        r0 = refills;
        rd(16'h0108);
        req_valid = 1'b0;
        wait_beat(2);
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("frozen_rsp", 64'(rsp_valid), 64'(0));
            @(negedge clk);
        end
        clk_en = 1'b1;
        wait_quiet();
        chk("stall_rsp", 64'(last_rsp), 64'(32'h0108_FEF7));
        chk("stall_refills", 64'(refills - r0), 64'(1));

        // random traffic over a few sets and tags
        for (int k = 0; k < 400; k++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 4) begin
                req_valid = 1'b0;
                fl();
            end else if (r < 15) begin
                req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end else begin
                a = AW'(($urandom_range(0, 3) << 6) |
                        ($urandom_range(0, 3) << 2) |
                        $urandom_range(0, 3));
                rd(a);
            end
        end
        wait_quiet();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
